reorder_buffer: RTL

- Circular in-order retirement queue directly downstream of rename.
- Each renamed instruction gets one entry at allocation, and the entry's index is returned as its ROB tag.
- Functional units mark entries complete by tag.
- The head entry retires in program order once complete. On retire it drives push_free_reg/freed_reg into free_pool (the old physical tag of rd) and reports the architectural commit.

---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/rob_ptr.sv | 34 +++
 rtl/reorder_buffer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, rename/ROB control-bit positions and the ROB entry record.
// Imported by every ROB file so entry layout is defined in exactly one place.
package reorder_buffer_pkg;

    localparam int PREG_WIDTH    = 6;
    localparam int AREG_WIDTH    = 5;
    localparam int PC_WIDTH      = 12;
    localparam int ROB_DEPTH     = 16;
    localparam int ROB_TAG_WIDTH = 4;

    // Bit positions inside the decoded control word travelling with an instruction
    localparam int REG_WRITE = 0;
    localparam int MEM_READ  = 1;
    localparam int MEM_WRITE = 2;
    localparam int BRANCH    = 3;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  reg_write;
        logic [AREG_WIDTH-1:0] areg;
        logic [PREG_WIDTH-1:0] preg;
        logic [PREG_WIDTH-1:0] old_preg;
        logic [PC_WIDTH-1:0]   pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH circular pointer; clear wins over increment; registered, 1-cycle update.
// No backpressure: the owner decides when to increment.
module rob_ptr
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH     = ROB_DEPTH,
    parameter int TAG_WIDTH = ROB_TAG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_inc,
    output logic [TAG_WIDTH-1:0] o_ptr
);

    localparam logic [TAG_WIDTH-1:0] LP_LAST = TAG_WIDTH'(DEPTH - 1);

    logic [TAG_WIDTH-1:0] r_ptr;
    logic [TAG_WIDTH-1:0] w_next;

    assign w_next = (r_ptr == LP_LAST) ? '0 : r_ptr + 1'b1;
    assign o_ptr  = r_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: alloc returns tail as tag, FUs complete by tag, head retires one cycle after done.
// Allocation is refused while full (no same-cycle retire bypass); flush clears everything at the edge.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int TAG_WIDTH  = ROB_TAG_WIDTH,
    parameter int PREG_WIDTH = reorder_buffer_pkg::PREG_WIDTH,
    parameter int AREG_WIDTH = reorder_buffer_pkg::AREG_WIDTH,
    parameter int PC_WIDTH   = reorder_buffer_pkg::PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    input  logic                  alloc_reg_write,
    input  logic [AREG_WIDTH-1:0] alloc_areg,
    input  logic [PREG_WIDTH-1:0] alloc_preg,
    input  logic [PREG_WIDTH-1:0] alloc_old_preg,
    input  logic [PC_WIDTH-1:0]   alloc_pc,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  cmpl_valid,
    input  logic [TAG_WIDTH-1:0]  cmpl_tag,
    input  logic                  flush,
    output logic                  retire_valid,
    output logic [AREG_WIDTH-1:0] retire_areg,
    output logic [PREG_WIDTH-1:0] retire_preg,
    output logic [PC_WIDTH-1:0]   retire_pc,
    output logic                  push_free_reg,
    output logic [PREG_WIDTH-1:0] freed_reg,
    output logic                  empty,
    output logic                  full
);

    localparam logic [TAG_WIDTH:0] LP_DEPTH = (TAG_WIDTH + 1)'(DEPTH);

    rob_entry_t           r_entries [DEPTH];
    logic [TAG_WIDTH:0]   r_count;
    logic [TAG_WIDTH-1:0] w_head;
    logic [TAG_WIDTH-1:0] w_tail;
    logic                 w_alloc_fire;
    rob_entry_t           w_head_ent;

    assign w_head_ent    = r_entries[w_head];
    assign full          = (r_count == LP_DEPTH);
    assign empty         = (r_count == '0);
    assign alloc_ready   = !full;
    assign alloc_tag     = w_tail;
    assign w_alloc_fire  = alloc_valid && alloc_ready && !flush;

    assign retire_valid  = w_head_ent.valid && w_head_ent.done && !flush;
    assign retire_areg   = w_head_ent.areg;
    assign retire_preg   = w_head_ent.preg;
    assign retire_pc     = w_head_ent.pc;
    assign freed_reg     = w_head_ent.old_preg;
    assign push_free_reg = retire_valid && w_head_ent.reg_write;

    rob_ptr #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (retire_valid),
        .o_ptr (w_head)
    );

    rob_ptr #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_inc (w_alloc_fire),
        .o_ptr (w_tail)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else begin
            case ({w_alloc_fire, retire_valid})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Completion is applied before the retire clear so a late duplicate
    // completion of the retiring head cannot resurrect its done bit.
    // Alloc and retire never target the same slot: head == tail only when empty or full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].done  <= 1'b0;
            end
        end else begin
            if (cmpl_valid && r_entries[cmpl_tag].valid) begin
                r_entries[cmpl_tag].done <= 1'b1;
            end
            if (retire_valid) begin
                r_entries[w_head].valid <= 1'b0;
                r_entries[w_head].done  <= 1'b0;
            end
            if (w_alloc_fire) begin
                r_entries[w_tail].valid     <= 1'b1;
                r_entries[w_tail].done      <= 1'b0;
                r_entries[w_tail].reg_write <= alloc_reg_write;
                r_entries[w_tail].areg      <= alloc_areg;
                r_entries[w_tail].preg      <= alloc_preg;
                r_entries[w_tail].old_preg  <= alloc_old_preg;
                r_entries[w_tail].pc        <= alloc_pc;
            end
        end
    end

endmodule
